// File: rtl/decode_irq_stage_if.sv
// ---------------------------------------------------------------------------
// decode_irq_stage_if
// Purpose : groups the fetch-side inputs (instruction, handshake, interrupt
//           requests) and the execute-side control bundle of the decode stage.
// Signals : ir / ir_valid / stall / flush / irq        fetch -> decode
//           out_valid, register addresses, ALU/memory/branch controls,
//           trap / trap_idx / illegal, ie / in_isr      decode -> execute
// Modports: master drives the fetch side and observes the bundle (testbench,
//           fetch stage); slave is the decode stage itself.
// ---------------------------------------------------------------------------
interface decode_irq_stage_if #(
  parameter int OFFSET_W  = 16,
  parameter int ALU_CON_W = 8,
  parameter int NUM_IRQ   = 4,
  parameter int IRQ_IDX_W = 3
);
  logic [15:0]          ir;
  logic                 ir_valid;
  logic                 stall;
  logic                 flush;
  logic [NUM_IRQ-1:0]   irq;

  logic                 out_valid;
  logic [2:0]           rd_adr1;
  logic [2:0]           rd_adr2;
  logic [2:0]           wr_adr;
  logic                 reg_write;
  logic                 alu_src2;
  logic [ALU_CON_W-1:0] alu_con;
  logic [OFFSET_W-1:0]  offset;
  logic                 mem_write;
  logic                 mem_to_reg;
  logic                 branch;
  logic [3:0]           branch_cond;
  logic                 trap;
  logic [IRQ_IDX_W-1:0] trap_idx;
  logic                 illegal;
  logic                 ie;
  logic                 in_isr;

  modport master (
    output ir, ir_valid, stall, flush, irq,
    input  out_valid, rd_adr1, rd_adr2, wr_adr, reg_write, alu_src2, alu_con,
           offset, mem_write, mem_to_reg, branch, branch_cond, trap, trap_idx,
           illegal, ie, in_isr
  );

  modport slave (
    input  ir, ir_valid, stall, flush, irq,
    output out_valid, rd_adr1, rd_adr2, wr_adr, reg_write, alu_src2, alu_con,
           offset, mem_write, mem_to_reg, branch, branch_cond, trap, trap_idx,
           illegal, ie, in_isr
  );
endinterface

// File: rtl/decode_irq_stage.sv
// ---------------------------------------------------------------------------
// decode_irq_stage
// Purpose : registered decode stage of the 16-bit RISC core with an
//           integrated prioritised interrupt sequencer. One instruction per
//           cycle becomes an execute-stage control bundle one cycle later;
//           when interrupts are enabled and a request is pending, a trap slot
//           is injected instead of decoding ir (fetch keeps ir stable).
// Ports   : clk    rising-edge clock
//           rst_n  asynchronous active-low reset
//           bus    decode_irq_stage_if.slave (fetch inputs, control bundle,
//                  ie / in_isr status)
// ---------------------------------------------------------------------------
module decode_irq_stage #(
  parameter int OFFSET_W  = 16,
  parameter int ALU_CON_W = 8,
  parameter int NUM_IRQ   = 4,
  parameter int IRQ_IDX_W = 3
) (
  input logic               clk,
  input logic               rst_n,
  decode_irq_stage_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    IN_ISR = 1'b1
  } state_t;

  typedef struct packed {
    logic                 out_valid;
    logic [2:0]           rd_adr1;
    logic [2:0]           rd_adr2;
    logic [2:0]           wr_adr;
    logic                 reg_write;
    logic                 alu_src2;
    logic [ALU_CON_W-1:0] alu_con;
    logic [OFFSET_W-1:0]  offset;
    logic                 mem_write;
    logic                 mem_to_reg;
    logic                 branch;
    logic [3:0]           branch_cond;
    logic                 trap;
    logic [IRQ_IDX_W-1:0] trap_idx;
    logic                 illegal;
  } bundle_t;

  state_t             state_q, state_d;
  bundle_t            bundle_q, bundle_d;
  logic               ie_q, ie_d;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] clr_s;
  logic               trap_go_s;
  logic [3:0]         op_s;

  // Lowest-numbered pending channel has the highest priority.
  function automatic logic [IRQ_IDX_W-1:0] lowest_idx(input logic [NUM_IRQ-1:0] p);
    lowest_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (p[i]) begin
        lowest_idx = IRQ_IDX_W'(i);
      end else begin
        lowest_idx = lowest_idx;
      end
    end
  endfunction

  assign op_s = bus.ir[15:12];

  // Next-slot selection: hold on stall, trap injection, bubble, or decode.
  always_comb begin
    bundle_d  = '0;
    ie_d      = ie_q;
    state_d   = state_q;
    clr_s     = '0;
    trap_go_s = (state_q == IDLE) && ie_q && (|pending_q) && !bus.stall && !bus.flush;
    if (bus.stall) begin
      bundle_d = bundle_q;
    end else if (trap_go_s) begin
      // Trap wins over whatever ir holds; ir is replayed after the trap slot.
      bundle_d.out_valid = 1'b1;
      bundle_d.trap      = 1'b1;
      bundle_d.trap_idx  = lowest_idx(pending_q);
      clr_s              = NUM_IRQ'(1) << lowest_idx(pending_q);
      ie_d               = 1'b0;
      state_d            = IN_ISR;
    end else if (bus.flush || !bus.ir_valid) begin
      bundle_d = '0;
    end else begin
      bundle_d.out_valid = 1'b1;
      case (op_s)
        4'd0: begin
          bundle_d.out_valid = 1'b1;
        end
        4'd1: begin
          bundle_d.wr_adr    = bus.ir[11:9];
          bundle_d.rd_adr1   = bus.ir[8:6];
          bundle_d.rd_adr2   = bus.ir[5:3];
          bundle_d.reg_write = 1'b1;
          bundle_d.alu_con   = ALU_CON_W'(1) << bus.ir[2:0];
        end
        4'd2: begin
          bundle_d.wr_adr    = bus.ir[11:9];
          bundle_d.rd_adr1   = bus.ir[8:6];
          bundle_d.rd_adr2   = bus.ir[5:3];
          bundle_d.reg_write = 1'b1;
          bundle_d.alu_src2  = 1'b1;
          bundle_d.offset    = {{(OFFSET_W-6){bus.ir[5]}}, bus.ir[5:0]};
          bundle_d.alu_con   = ALU_CON_W'(1);
        end
        4'd3: begin
          bundle_d.wr_adr     = bus.ir[11:9];
          bundle_d.rd_adr1    = bus.ir[8:6];
          bundle_d.alu_src2   = 1'b1;
          bundle_d.offset     = {{(OFFSET_W-6){bus.ir[5]}}, bus.ir[5:0]};
          bundle_d.alu_con    = ALU_CON_W'(1);
          bundle_d.reg_write  = 1'b1;
          bundle_d.mem_to_reg = 1'b1;
        end
        4'd4: begin
          bundle_d.rd_adr1   = bus.ir[8:6];
          bundle_d.rd_adr2   = bus.ir[11:9];
          bundle_d.alu_src2  = 1'b1;
          bundle_d.offset    = {{(OFFSET_W-6){bus.ir[5]}}, bus.ir[5:0]};
          bundle_d.alu_con   = ALU_CON_W'(1);
          bundle_d.mem_write = 1'b1;
        end
        4'd5: begin
          bundle_d.branch      = 1'b1;
          bundle_d.branch_cond = bus.ir[11:8];
          bundle_d.offset      = {{(OFFSET_W-8){bus.ir[7]}}, bus.ir[7:0]};
        end
        4'd6: begin
          ie_d = 1'b1;
        end
        4'd7: begin
          ie_d = 1'b0;
        end
        4'd8: begin
          ie_d    = 1'b1;
          state_d = IDLE;
        end
        default: begin
          bundle_d.illegal = 1'b1;
        end
      endcase
    end
    // A request arriving on the same edge as its clear must survive.
    pending_d = (pending_q & ~clr_s) | bus.irq;
  end

  // Sequencer state, interrupt enable, pending latch and output bundle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ie_q      <= 1'b0;
      pending_q <= '0;
      bundle_q  <= '0;
    end else begin
      state_q   <= state_d;
      ie_q      <= ie_d;
      pending_q <= pending_d;
      bundle_q  <= bundle_d;
    end
  end

  assign bus.out_valid   = bundle_q.out_valid;
  assign bus.rd_adr1     = bundle_q.rd_adr1;
  assign bus.rd_adr2     = bundle_q.rd_adr2;
  assign bus.wr_adr      = bundle_q.wr_adr;
  assign bus.reg_write   = bundle_q.reg_write;
  assign bus.alu_src2    = bundle_q.alu_src2;
  assign bus.alu_con     = bundle_q.alu_con;
  assign bus.offset      = bundle_q.offset;
  assign bus.mem_write   = bundle_q.mem_write;
  assign bus.mem_to_reg  = bundle_q.mem_to_reg;
  assign bus.branch      = bundle_q.branch;
  assign bus.branch_cond = bundle_q.branch_cond;
  assign bus.trap        = bundle_q.trap;
  assign bus.trap_idx    = bundle_q.trap_idx;
  assign bus.illegal     = bundle_q.illegal;
  assign bus.ie          = ie_q;
  assign bus.in_isr      = (state_q == IN_ISR);

endmodule

// File: tb/tb_decode_irq_stage.sv
// ---------------------------------------------------------------------------
// tb_decode_irq_stage
// Purpose : self-checking bench for decode_irq_stage. Directed steps follow
//           the decode / stall / flush / interrupt / reset scenarios, then a
//           randomised phase is checked against an instruction-level model.
// ---------------------------------------------------------------------------
module tb_decode_irq_stage;
  localparam int OFFSET_W  = 16;
  localparam int ALU_CON_W = 8;
  localparam int NUM_IRQ   = 4;
  localparam int IRQ_IDX_W = 3;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  decode_irq_stage_if #(.OFFSET_W(OFFSET_W), .ALU_CON_W(ALU_CON_W),
                        .NUM_IRQ(NUM_IRQ), .IRQ_IDX_W(IRQ_IDX_W)) bus ();

  decode_irq_stage #(.OFFSET_W(OFFSET_W), .ALU_CON_W(ALU_CON_W),
                     .NUM_IRQ(NUM_IRQ), .IRQ_IDX_W(IRQ_IDX_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        out_valid;
    logic [2:0]  rd_adr1;
    logic [2:0]  rd_adr2;
    logic [2:0]  wr_adr;
    logic        reg_write;
    logic        alu_src2;
    logic [7:0]  alu_con;
    logic [15:0] offset;
    logic        mem_write;
    logic        mem_to_reg;
    logic        branch;
    logic [3:0]  branch_cond;
    logic        trap;
    logic [2:0]  trap_idx;
    logic        illegal;
    logic        ie;
    logic        in_isr;
  } obs_t;

  // Reference state: expected outputs, enable flag, pending mask, ISR flag.
  obs_t exp_s;
  bit   m_ie;
  bit   m_isr;
  int   m_pend;

  function automatic obs_t observe();
    obs_t o;
    o.out_valid   = bus.out_valid;
    o.rd_adr1     = bus.rd_adr1;
    o.rd_adr2     = bus.rd_adr2;
    o.wr_adr      = bus.wr_adr;
    o.reg_write   = bus.reg_write;
    o.alu_src2    = bus.alu_src2;
    o.alu_con     = bus.alu_con;
    o.offset      = bus.offset;
    o.mem_write   = bus.mem_write;
    o.mem_to_reg  = bus.mem_to_reg;
    o.branch      = bus.branch;
    o.branch_cond = bus.branch_cond;
    o.trap        = bus.trap;
    o.trap_idx    = bus.trap_idx;
    o.illegal     = bus.illegal;
    o.ie          = bus.ie;
    o.in_isr      = bus.in_isr;
    return o;
  endfunction

  // Instruction meaning, with immediates sign-extended arithmetically.
  function automatic obs_t decode_ref(input logic [15:0] i);
    obs_t o;
    int   op;
    int   s6;
    int   s8;
    o  = '0;
    op = int'(i[15:12]);
    s6 = int'(i[5:0]);
    s8 = int'(i[7:0]);
    if (s6 >= 32) s6 = s6 - 64;
    if (s8 >= 128) s8 = s8 - 256;
    o.out_valid = 1'b1;
    case (op)
      1, 2: begin
        o.wr_adr = i[11:9]; o.rd_adr1 = i[8:6]; o.rd_adr2 = i[5:3];
        o.reg_write = 1'b1;
        if (op == 1) o.alu_con = 8'(32'd1 << i[2:0]);
        else begin o.alu_con = 8'd1; o.alu_src2 = 1'b1; o.offset = 16'(s6); end
      end
      3: begin
        o.wr_adr = i[11:9]; o.rd_adr1 = i[8:6]; o.alu_src2 = 1'b1;
        o.offset = 16'(s6); o.alu_con = 8'd1; o.reg_write = 1'b1; o.mem_to_reg = 1'b1;
      end
      4: begin
        o.rd_adr1 = i[8:6]; o.rd_adr2 = i[11:9]; o.alu_src2 = 1'b1;
        o.offset = 16'(s6); o.alu_con = 8'd1; o.mem_write = 1'b1;
      end
      5: begin
        o.branch = 1'b1; o.branch_cond = i[11:8]; o.offset = 16'(s8);
      end
      0, 6, 7, 8: o.out_valid = 1'b1;
      default: o.illegal = 1'b1;
    endcase
    return o;
  endfunction

  // Advance the reference by one clock edge given the inputs at that edge.
  task automatic model_edge(input logic [15:0] i, input logic iv, input logic st,
                            input logic fl, input logic [3:0] rq);
    int idx;
    int op;
    op = int'(i[15:12]);
    if (st) begin
      m_pend = m_pend | int'(rq);
    end else if (!m_isr && m_ie && m_pend != 0 && !fl) begin
      idx = 0;
      while (((m_pend >> idx) & 1) == 0) idx++;
      exp_s = '0;
      exp_s.out_valid = 1'b1;
      exp_s.trap      = 1'b1;
      exp_s.trap_idx  = 3'(idx);
      m_ie   = 1'b0;
      m_isr  = 1'b1;
      m_pend = (m_pend & ~(1 << idx)) | int'(rq);
    end else begin
      m_pend = m_pend | int'(rq);
      if (fl || !iv) begin
        exp_s = '0;
      end else begin
        exp_s = decode_ref(i);
        if (op == 6 || op == 8) m_ie = 1'b1;
        if (op == 7) m_ie = 1'b0;
        if (op == 8) m_isr = 1'b0;
      end
    end
    exp_s.ie     = m_ie;
    exp_s.in_isr = m_isr;
  endtask

  task automatic model_reset();
    exp_s  = '0;
    m_ie   = 1'b0;
    m_isr  = 1'b0;
    m_pend = 0;
  endtask

  task automatic cmp_model(input string tag);
    obs_t got;
    got = observe();
    tests++;
    assert (got === exp_s) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp_s);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  // Drive one cycle of inputs, step the model at the edge, compare after it.
  task automatic step(input string tag, input logic [15:0] i, input logic iv,
                      input logic st, input logic fl, input logic [3:0] rq);
    @(negedge clk);
    bus.ir = i; bus.ir_valid = iv; bus.stall = st; bus.flush = fl; bus.irq = rq;
    @(posedge clk);
    model_edge(i, iv, st, fl, rq);
    #1;
    cmp_model(tag);
  endtask

  initial begin
    logic [15:0] r_ir;
    int          r_op;
    rst_n = 1'b0;
    bus.ir = 16'h0000; bus.ir_valid = 1'b0; bus.stall = 1'b0;
    bus.flush = 1'b0; bus.irq = 4'b0000;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    cmp_model("reset_state");
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // ALU-R decode
    step("alu_r", 16'h1299, 1'b1, 1'b0, 1'b0, 4'b0000);
    chk("alu_r_wr_adr", 32'(bus.wr_adr), 32'd1);
    chk("alu_r_rd_adr1", 32'(bus.rd_adr1), 32'd2);
    chk("alu_r_rd_adr2", 32'(bus.rd_adr2), 32'd3);
    chk("alu_r_alu_con", 32'(bus.alu_con), 32'h02);
    chk("alu_r_reg_write", 32'(bus.reg_write), 32'd1);

    // Immediates
    step("load", 16'h327F, 1'b1, 1'b0, 1'b0, 4'b0000);
    chk("load_offset", 32'(bus.offset), 32'hFFFF);
    chk("load_mem_to_reg", 32'(bus.mem_to_reg), 32'd1);
    chk("load_alu_src2", 32'(bus.alu_src2), 32'd1);
    step("branch", 16'h5380, 1'b1, 1'b0, 1'b0, 4'b0000);
    chk("branch_cond", 32'(bus.branch_cond), 32'd3);
    chk("branch_offset", 32'(bus.offset), 32'hFF80);

    // Stall freezes the bundle, flush drops an IEN without side effect
    for (int k = 0; k < 3; k++) begin
      step("stall", 16'h1FFF, 1'b1, 1'b1, 1'b0, 4'b0000);
      chk("stall_offset", 32'(bus.offset), 32'hFF80);
    end
    step("flush", 16'h6000, 1'b1, 1'b0, 1'b1, 4'b0000);
    chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_ie", 32'(bus.ie), 32'd0);

    // Priority: IEN, requests on channels 1 and 3
    step("ien", 16'h6000, 1'b1, 1'b0, 1'b0, 4'b0000);
    chk("ien_ie", 32'(bus.ie), 32'd1);
    step("irq_latch", 16'h0000, 1'b1, 1'b0, 1'b0, 4'b1010);
    step("trap1", 16'h0000, 1'b1, 1'b0, 1'b0, 4'b0000);
    chk("trap1_trap", 32'(bus.trap), 32'd1);
    chk("trap1_idx", 32'(bus.trap_idx), 32'd1);
    chk("trap1_ie", 32'(bus.ie), 32'd0);
    chk("trap1_in_isr", 32'(bus.in_isr), 32'd1);
    step("isr_body", 16'h1299, 1'b1, 1'b0, 1'b0, 4'b0000);
    chk("isr_no_nest", 32'(bus.trap), 32'd0);
    step("rti1", 16'h8000, 1'b1, 1'b0, 1'b0, 4'b0000);
    step("trap3", 16'h0000, 1'b1, 1'b0, 1'b0, 4'b0000);
    chk("trap3_idx", 32'(bus.trap_idx), 32'd3);
    step("rti2", 16'h8000, 1'b1, 1'b0, 1'b0, 4'b0000);

    // IOF masks a held request until the next IEN
    step("iof", 16'h7000, 1'b1, 1'b0, 1'b0, 4'b0000);
    for (int k = 0; k < 5; k++) begin
      step("masked", 16'h0000, 1'b1, 1'b0, 1'b0, 4'b0001);
      chk("masked_no_trap", 32'(bus.trap), 32'd0);
    end
    step("ien2", 16'h6000, 1'b1, 1'b0, 1'b0, 4'b0000);
    step("trap0", 16'h0000, 1'b1, 1'b0, 1'b0, 4'b0000);
    chk("trap0_trap", 32'(bus.trap), 32'd1);
    chk("trap0_idx", 32'(bus.trap_idx), 32'd0);

    // Asynchronous reset in the middle of an ISR with a request pending
    step("pend2", 16'h0000, 1'b1, 1'b0, 1'b0, 4'b0100);
    chk("pend2_in_isr", 32'(bus.in_isr), 32'd1);
    @(negedge clk);
    bus.irq = 4'b0000;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    cmp_model("rst_mid");
    chk("rst_mid_in_isr", 32'(bus.in_isr), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step("illegal", 16'hF000, 1'b1, 1'b0, 1'b0, 4'b0000);
    chk("illegal_flag", 32'(bus.illegal), 32'd1);
    chk("illegal_valid", 32'(bus.out_valid), 32'd1);
    step("no_trap_after_rst", 16'h0000, 1'b1, 1'b0, 1'b0, 4'b0000);
    chk("rst_pending_cleared", 32'(bus.trap), 32'd0);

    // Randomised traffic, biased toward IEN/RTI so traps occur often
    for (int n = 0; n < 400; n++) begin
      r_op = $urandom_range(0, 19);
      if (r_op >= 18) r_op = 8;
      else if (r_op >= 16) r_op = 6;
      r_ir = {4'(r_op), 12'($urandom)};
      step("random", r_ir, ($urandom_range(0, 9) != 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 7) == 0),
           (($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/decode_irq_stage.md
Name: decode_irq_stage

Overview:
- Registered instruction-decode stage for the 16-bit RISC core, sitting between fetch and execute.
- Converts IR into the execute-stage control bundle, one instruction per cycle.
- Supports stall and flush.
- Integrates an NUM_IRQ-channel prioritised interrupt sequencer: it injects trap slots into the pipeline and owns the IEN/IOF/RTI state.

Parameters:
- OFFSET_W, 16, width of the sign-extended offset output (must be >= 8).
- ALU_CON_W, 8, width of the one-hot ALU control output (must be >= 8).
- NUM_IRQ, 4, number of interrupt request lines (1..8).
- IRQ_IDX_W, 3, width of the trap index output (must satisfy 2^IRQ_IDX_W >= NUM_IRQ).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- ir  in  16  fetched instruction.
- ir_valid  in  1  ir holds a real instruction this cycle.
- stall  in  1  hold all output registers; ir is not consumed.
- flush  in  1  discard the current ir; the output becomes a bubble.
- irq  in  NUM_IRQ  level interrupt requests.
- out_valid  out  1  control bundle is valid.
- rd_adr1, rd_adr2, wr_adr  out  3 each  register-file addresses.
- reg_write  out  1  write-enable for the register file.
- alu_src2  out  1  1 = offset feeds the ALU second operand.
- alu_con  out  ALU_CON_W  one-hot ALU operation.
- offset  out  OFFSET_W  sign-extended immediate.
- mem_write, mem_to_reg, branch  out  1 each  execute/memory controls.
- branch_cond  out  4  branch condition code.
- trap  out  1  slot is an injected interrupt.
- trap_idx  out  IRQ_IDX_W  channel being serviced.
- illegal  out  1  undefined opcode.
- ie  out  1  global interrupt enable.
- in_isr  out  1  sequencer is in the IN_ISR state.

Behaviour:
- Decode fields: op=ir[15:12], rd=ir[11:9], rs1=ir[8:6], rs2=ir[5:3], fn=ir[2:0], imm6=ir[5:0], imm8=ir[7:0].
- op 0 NOP: all controls 0, out_valid 1.
- op 1 ALU-R: wr_adr=rd, rd_adr1=rs1, rd_adr2=rs2, reg_write=1, alu_con=1<<fn.
- op 2 ALU-I: same as op 1 but alu_src2=1, offset=sext(imm6), alu_con=1<<0 (ADD).
- op 3 LOAD: wr_adr=rd, rd_adr1=rs1, alu_src2=1, offset=sext(imm6), alu_con=ADD, reg_write=1, mem_to_reg=1.
- op 4 STORE: rd_adr1=rs1, rd_adr2=rd, alu_src2=1, offset=sext(imm6), alu_con=ADD, mem_write=1.
- op 5 BRANCH: branch=1, branch_cond=ir[11:8], offset=sext(imm8).
- op 6 IEN: sets ie at the edge the slot is registered.
- op 7 IOF: clears ie at the edge the slot is registered.
- op 8 RTI: sets ie, leaves IN_ISR, goes to IDLE.
- op 9..15: illegal=1, all other controls 0, out_valid 1.
- Fields not listed for an opcode are 0.
- Latency: 1 cycle. ir sampled at edge N appears on the outputs after edge N.
- stall=1: every output register, ie, pending and the FSM hold. pending still ORs in new irq.
- flush=1 without stall: next slot is a bubble (out_valid=0, all controls 0). No IEN/IOF/RTI side effect. Pending interrupts are not lost.
- stall wins over flush.
- ir_valid=0 without stall: bubble.
- pending[NUM_IRQ-1:0]: pending |= irq every cycle. A channel's bit clears only on the edge its trap slot is issued. Clear and new set in the same cycle: set wins.
- FSM state IDLE: if ie=1, |pending, !stall and !flush, the next slot is a trap slot and the state goes to IN_ISR, else the state stays IDLE.
- Trap slot contents: out_valid=1, trap=1, trap_idx = lowest set pending index, all other controls 0. ir is not consumed; fetch must hold ir.
- Trap issue clears ie.
- FSM state IN_ISR: in_isr=1. No further traps are issued. Normal decode continues. RTI returns to IDLE. IEN inside an ISR sets ie but does not nest.
- Trap and IEN/IOF cannot occur in the same slot; the trap has priority.
- Reset (asynchronous, any time, including mid-trap): all outputs 0, pending 0, ie 0, state IDLE. The first slot after reset release is decoded normally.

Test Plan:
- ALU-R: ir=16'h1299 (rd=1, rs1=2, rs2=3, fn=1), ir_valid=1 -> one cycle later wr_adr=1, rd_adr1=2, rd_adr2=3, reg_write=1, alu_con=8'h02, out_valid=1.
- Immediates: LOAD ir=16'h327F -> offset=16'hFFFF, mem_to_reg=1, alu_src2=1. BRANCH ir=16'h5380 -> branch_cond=3, offset=16'hFF80.
- Stall/flush: stall high 3 cycles -> outputs frozen at the previous bundle. flush with ir=16'h6000 -> out_valid=0 and ie stays 0.
- Interrupt priority: IEN issued, then irq=4'b1010 -> trap=1, trap_idx=1, ie=0, in_isr=1. RTI -> next slot trap_idx=3.
- IOF then irq=4'b0001 held 5 cycles -> no trap. pending[0]=1 remains and traps 1 cycle after the IEN slot.
- Reset mid-ISR: in_isr=1 and pending=4'b0100, assert rst_n=0 between edges -> all outputs 0 immediately. After release, illegal ir=16'hF000 -> illegal=1, out_valid=1.
